// File: rtl/sensor_hub_dispatcher.sv
// Multi-channel sensor hub: decodes host requests, runs 40-bit front-ends, validates frames and
// schedules continuous reads. Fractional commands 07/08 are built in when SENSOR_FRAC_EN is defined.
module sensor_hub_dispatcher #(
  parameter int         NUM_SENSORS    = 8,
  parameter logic [7:0] ADDR_BASE      = 8'h01,
  parameter int         LOOP_PERIOD    = 100000000,
  parameter int         TIMEOUT_CYCLES = 50000000,
  parameter int         CNT_W          = 27
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [7:0]                request_command,
  input  logic [7:0]                request_address,
  output logic [NUM_SENSORS-1:0]    sensor_enable,
  input  logic [40*NUM_SENSORS-1:0] sensor_data,
  input  logic [NUM_SENSORS-1:0]    sensor_error,
  input  logic [NUM_SENSORS-1:0]    sensor_done,
  output logic                      busy,
  output logic                      response_valid,
  output logic [7:0]                response_command,
  output logic [7:0]                response_value,
  output logic [7:0]                response_address,
  output logic [2:0]                dbg_state
);
  localparam int CH_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
  localparam logic [CNT_W-1:0] LOOP_LAST = CNT_W'(LOOP_PERIOD - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_START, S_WAIT, S_CHECK, S_RESP} state_t;
  state_t state_q, state_d;

  logic [7:0]             cmd_q, cmd_d, addr_q, addr_d;
  logic [CH_W-1:0]        chan_q, chan_d;
  logic [NUM_SENSORS-1:0] loop_on_q, loop_on_d, loop_hum_q, loop_hum_d, pending_q, pending_d;
  logic [CNT_W-1:0]       period_q, period_d, timeout_q, timeout_d;
  logic [39:0]            frame_q, frame_d;
  logic                   fault_q, fault_d, busy_q, busy_d, resp_valid_q, resp_valid_d;
  logic [7:0]             stage_cmd_q, stage_cmd_d, stage_val_q, stage_val_d;
  logic [7:0]             resp_cmd_q, resp_cmd_d, resp_val_q, resp_val_d, resp_addr_q, resp_addr_d;

  logic            host_go, loop_go, in_range, loop_blocked, is_stop, is_read;
  logic            wait_exit, frame_ok, tick;
  logic [CH_W-1:0] pend_sel;
  logic [7:0]      byte_sum;

  // Host handshake: a request is taken only when enable=1 in IDLE with busy=0; anything else is
  // dropped. busy stays high through the response_valid cycle, so the host waits for busy=0.
  always_comb begin : classify
    host_go  = (state_q == S_IDLE) && !busy_q && enable;
    loop_go  = (state_q == S_IDLE) && !busy_q && !enable && (|pending_q);
    pend_sel = '0;
    for (int i = NUM_SENSORS - 1; i >= 0; i--)
      if (pending_q[i]) pend_sel = CH_W'(i);
    in_range = (addr_q >= ADDR_BASE) &&
               ({1'b0, addr_q} < ({1'b0, ADDR_BASE} + 9'(NUM_SENSORS)));
    loop_blocked = loop_on_q[chan_q] && !(cmd_q >= 8'h03 && cmd_q <= 8'h06);
    is_stop = (cmd_q == 8'h05) || (cmd_q == 8'h06);
    case (cmd_q)
      8'hAC, 8'h01, 8'h02, 8'h03, 8'h04: is_read = 1'b1;
`ifdef SENSOR_FRAC_EN
      8'h07, 8'h08:                      is_read = 1'b1;
`endif
      default:                           is_read = 1'b0;
    endcase
    wait_exit = sensor_done[chan_q] || sensor_error[chan_q] || (timeout_q == TO_LAST);
    byte_sum  = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];
    frame_ok  = !fault_q && (byte_sum == frame_q[7:0]);
    tick      = (|loop_on_q) && (period_q == LOOP_LAST);
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (host_go || loop_go) state_d = S_DECODE;
      S_DECODE: state_d = (in_range && !loop_blocked && !is_stop && is_read) ? S_START : S_RESP;
      S_START:  state_d = S_WAIT;
      S_WAIT:   if (wait_exit) state_d = S_CHECK;
      S_CHECK:  state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin : datapath
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    chan_d       = chan_q;
    loop_on_d    = loop_on_q;
    loop_hum_d   = loop_hum_q;
    pending_d    = pending_q;
    timeout_d    = timeout_q;
    frame_d      = frame_q;
    fault_d      = fault_q;
    busy_d       = busy_q;
    stage_cmd_d  = stage_cmd_q;
    stage_val_d  = stage_val_q;
    resp_valid_d = 1'b0;
    resp_cmd_d   = resp_cmd_q;
    resp_val_d   = resp_val_q;
    resp_addr_d  = resp_addr_q;
    period_d     = (!(|loop_on_q) || tick) ? '0 : period_q + CNT_W'(1);
    if (tick) pending_d = pending_q | loop_on_q;
    if (host_go) begin
      cmd_d  = request_command;
      addr_d = request_address;
      chan_d = CH_W'(request_address - ADDR_BASE);
      busy_d = 1'b1;
    end else if (loop_go) begin
      cmd_d  = loop_hum_q[pend_sel] ? 8'h04 : 8'h03;
      addr_d = ADDR_BASE + 8'(pend_sel);
      chan_d = pend_sel;
      pending_d[pend_sel] = 1'b0;
      busy_d = 1'b1;
    end
    if (resp_valid_q) busy_d = 1'b0;
    case (state_q)
      S_DECODE: begin
        if (!in_range) begin
          stage_cmd_d = 8'hEE; stage_val_d = 8'hEE;
        end else if (loop_blocked) begin
          stage_cmd_d = 8'hFF; stage_val_d = 8'hFF;
        end else if (is_stop) begin
          loop_on_d[chan_q] = 1'b0;
          stage_cmd_d = (cmd_q == 8'h05) ? 8'h0A : 8'h0B;
          stage_val_d = stage_cmd_d;
        end else if (!is_read) begin
          stage_cmd_d = 8'h45; stage_val_d = 8'h45;
        end
      end
      S_START: timeout_d = '0;
      S_WAIT: begin
        if (wait_exit) begin
          frame_d = sensor_data[40*chan_q +: 40];
          // Done wins over a same-cycle timeout; an error flag always marks the frame bad.
          fault_d = sensor_error[chan_q] || !sensor_done[chan_q];
        end else begin
          timeout_d = timeout_q + CNT_W'(1);
        end
      end
      S_CHECK: begin
        stage_cmd_d = 8'h1F; stage_val_d = 8'h1F;
        if (frame_ok) begin
          case (cmd_q)
            8'hAC: begin stage_cmd_d = 8'h07; stage_val_d = 8'h07; end
            8'h01: begin stage_cmd_d = 8'h09; stage_val_d = frame_q[23:16]; end
            8'h02: begin stage_cmd_d = 8'h08; stage_val_d = frame_q[39:32]; end
            8'h03: begin
              stage_cmd_d = 8'h0D; stage_val_d = frame_q[23:16];
              loop_on_d[chan_q] = 1'b1; loop_hum_d[chan_q] = 1'b0;
            end
            8'h04: begin
              stage_cmd_d = 8'h0E; stage_val_d = frame_q[39:32];
              loop_on_d[chan_q] = 1'b1; loop_hum_d[chan_q] = 1'b1;
            end
            8'h07:   begin stage_cmd_d = 8'h19; stage_val_d = frame_q[15:8]; end
            8'h08:   begin stage_cmd_d = 8'h18; stage_val_d = frame_q[31:24]; end
            default: ;
          endcase
        end
      end
      S_RESP: begin
        resp_valid_d = 1'b1;
        resp_cmd_d   = stage_cmd_q;
        resp_val_d   = stage_val_q;
        resp_addr_d  = addr_q;
      end
      default: ;
    endcase
    pending_d = pending_d & loop_on_d;
  end

  always_ff @(posedge clock) begin : state_reg
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock) begin : data_reg
    if (!reset_n) begin
      cmd_q <= '0; addr_q <= '0; chan_q <= '0;
      loop_on_q <= '0; loop_hum_q <= '0; pending_q <= '0;
      period_q <= '0; timeout_q <= '0; frame_q <= '0; fault_q <= 1'b0;
      busy_q <= 1'b0; resp_valid_q <= 1'b0;
      stage_cmd_q <= '0; stage_val_q <= '0;
      resp_cmd_q <= '0; resp_val_q <= '0; resp_addr_q <= '0;
    end else begin
      cmd_q <= cmd_d; addr_q <= addr_d; chan_q <= chan_d;
      loop_on_q <= loop_on_d; loop_hum_q <= loop_hum_d; pending_q <= pending_d;
      period_q <= period_d; timeout_q <= timeout_d; frame_q <= frame_d; fault_q <= fault_d;
      busy_q <= busy_d; resp_valid_q <= resp_valid_d;
      stage_cmd_q <= stage_cmd_d; stage_val_q <= stage_val_d;
      resp_cmd_q <= resp_cmd_d; resp_val_q <= resp_val_d; resp_addr_q <= resp_addr_d;
    end
  end

  always_comb begin : outputs
    sensor_enable = '0;
    if (state_q == S_START || state_q == S_WAIT) sensor_enable[chan_q] = 1'b1;
    busy             = busy_q;
    response_valid   = resp_valid_q;
    response_command = resp_cmd_q;
    response_value   = resp_val_q;
    response_address = resp_addr_q;
    dbg_state        = state_q;
  end
endmodule

// File: tb/tb_sensor_hub_dispatcher.sv
// Directed bench for sensor_hub_dispatcher: behavioural front-ends on 8 channels, short loop
// period and timeout, hand-computed responses per scenario.
module tb_sensor_hub_dispatcher;
  localparam int N = 8;

  logic               clock = 1'b0;
  logic               reset_n, enable;
  logic [7:0]         request_command, request_address;
  logic [N-1:0]       sensor_enable, sensor_error, sensor_done;
  logic [40*N-1:0]    sensor_data;
  logic               busy, response_valid;
  logic [7:0]         response_command, response_value, response_address;
  logic [2:0]         dbg_state;

  logic [39:0] fe_frame [N];
  logic [N-1:0] fe_silent, fe_err;
  int fe_cnt [N];
  int checks = 0;
  int errors = 0;
  int resp_count = 0;

  sensor_hub_dispatcher #(
    .NUM_SENSORS(N), .ADDR_BASE(8'h01), .LOOP_PERIOD(100), .TIMEOUT_CYCLES(50), .CNT_W(27)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .request_command(request_command), .request_address(request_address),
    .sensor_enable(sensor_enable), .sensor_data(sensor_data),
    .sensor_error(sensor_error), .sensor_done(sensor_done),
    .busy(busy), .response_valid(response_valid), .response_command(response_command),
    .response_value(response_value), .response_address(response_address),
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  // Front-end model: done (or error) three cycles into a read, unless the channel is silent.
  initial begin : front_end
    sensor_done = '0; sensor_error = '0; sensor_data = '0;
    for (int i = 0; i < N; i++) fe_cnt[i] = 0;
    forever begin
      @(negedge clock);
      sensor_done = '0; sensor_error = '0;
      for (int i = 0; i < N; i++) begin
        sensor_data[40*i +: 40] = fe_frame[i];
        if (sensor_enable[i]) begin
          fe_cnt[i]++;
          if (fe_cnt[i] == 3 && !fe_silent[i]) begin
            if (fe_err[i]) sensor_error[i] = 1'b1;
            else           sensor_done[i]  = 1'b1;
          end
        end else begin
          fe_cnt[i] = 0;
        end
      end
    end
  end

  initial begin : resp_monitor
    forever begin
      @(posedge clock); #1;
      if (response_valid) resp_count++;
    end
  end

  task automatic send_req(input logic [7:0] cmd, input logic [7:0] addr);
    int n = 0;
    while (busy === 1'b1 && n < 300) begin @(negedge clock); n++; end
    if (busy !== 1'b0) begin
      errors++; checks++;
      $display("FAIL send_req busy stuck=%b required 0", busy);
    end
    enable = 1'b1; request_command = cmd; request_address = addr;
    @(negedge clock);
    enable = 1'b0;
  endtask

  task automatic wait_resp(input int max_cyc, output logic got, output logic [7:0] c,
                           output logic [7:0] v, output logic [7:0] a, output int cyc);
    got = 1'b0; c = '0; v = '0; a = '0; cyc = 0;
    while (!got && cyc < max_cyc) begin
      @(negedge clock); cyc++;
      if (response_valid === 1'b1) begin
        got = 1'b1; c = response_command; v = response_value; a = response_address;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; request_command = '0; request_address = '0;
    repeat (3) @(negedge clock);
    checks++;
    if ({sensor_enable, busy, response_valid, response_command, response_value,
         response_address} !== '0) begin
      errors++;
      $display("FAIL reset_outputs en=%h busy=%b valid=%b resp=%h/%h/%h required all 0",
               sensor_enable, busy, response_valid, response_command, response_value,
               response_address);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_read_temp();
    logic got; logic [7:0] c, v, a; int cyc;
    send_req(8'h01, 8'h01);
    wait_resp(40, got, c, v, a, cyc);
    checks++;
    if (!got || {c, v, a} !== 24'h09_19_01) begin
      errors++; $display("FAIL read_temp got=%b resp=%h/%h/%h required 09/19/01", got, c, v, a);
    end
    checks++;
    if (sensor_enable !== '0 || busy !== 1'b1) begin
      errors++; $display("FAIL read_temp_en en=%h busy=%b required 00/1", sensor_enable, busy);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL busy_release busy=%b required 0", busy);
    end
  endtask

  task automatic test_reads();
    logic got; logic [7:0] c, v, a; int cyc;
    logic [31:0] vec [6];
    // {cmd, addr, exp_cmd, exp_val}; ch2 bad checksum, ch4 error flag, ch7 checksum with carry
    vec = '{32'h02_01_08_32, 32'hAC_01_07_07, 32'h02_03_1F_1F,
            32'hAC_08_07_07, 32'h02_08_08_FF, 32'h01_05_1F_1F};
    for (int k = 0; k < 6; k++) begin
      send_req(vec[k][31:24], vec[k][23:16]);
      wait_resp(40, got, c, v, a, cyc);
      checks++;
      if (!got || {c, v, a} !== {vec[k][15:0], vec[k][23:16]}) begin
        errors++;
        $display("FAIL read_%0d got=%b resp=%h/%h/%h required %h/%h/%h", k, got, c, v, a,
                 vec[k][15:8], vec[k][7:0], vec[k][23:16]);
      end
    end
  endtask

  task automatic test_decode();
    logic got; logic [7:0] c, v, a; int cyc;
    logic [31:0] vec [9];
    vec = '{32'h01_20_EE_EE, 32'h01_00_EE_EE, 32'hAC_09_EE_EE, 32'h55_01_45_45,
            32'h05_01_0A_0A, 32'h06_02_0B_0B, 32'h00_03_45_45,
`ifdef SENSOR_FRAC_EN
            32'h09_01_45_45, 32'hFF_01_45_45};
`else
            32'h07_01_45_45, 32'h08_01_45_45};
`endif
    for (int k = 0; k < 9; k++) begin
      send_req(vec[k][31:24], vec[k][23:16]);
      wait_resp(10, got, c, v, a, cyc);
      checks++;
      if (!got || cyc != 2 || {c, v, a} !== {vec[k][15:0], vec[k][23:16]}) begin
        errors++;
        $display("FAIL decode_%0d got=%b cyc=%0d resp=%h/%h/%h required 2 %h/%h/%h", k, got,
                 cyc, c, v, a, vec[k][15:8], vec[k][7:0], vec[k][23:16]);
      end
    end
`ifdef SENSOR_FRAC_EN
    send_req(8'h07, 8'h02);
    wait_resp(40, got, c, v, a, cyc);
    checks++;
    if (!got || {c, v, a} !== 24'h19_03_02) begin
      errors++; $display("FAIL frac_temp got=%b resp=%h/%h/%h required 19/03/02", got, c, v, a);
    end
    send_req(8'h08, 8'h02);
    wait_resp(40, got, c, v, a, cyc);
    checks++;
    if (!got || {c, v, a} !== 24'h18_05_02) begin
      errors++; $display("FAIL frac_hum got=%b resp=%h/%h/%h required 18/05/02", got, c, v, a);
    end
`endif
  endtask

  task automatic test_timeout();
    logic got; logic [7:0] c, v, a; int cyc, snap;
    send_req(8'h01, 8'h04);
    repeat (10) @(negedge clock);
    enable = 1'b1; request_command = 8'hAC; request_address = 8'h01;
    @(negedge clock);
    enable = 1'b0;
    wait_resp(100, got, c, v, a, cyc);
    checks++;
    if (!got || {c, v, a} !== 24'h1F_1F_04 || (cyc + 11) < 50 || (cyc + 11) > 60) begin
      errors++;
      $display("FAIL timeout got=%b lat=%0d resp=%h/%h/%h required 50..60 1F/1F/04", got,
               cyc + 11, c, v, a);
    end
    checks++;
    if (sensor_enable !== '0) begin
      errors++; $display("FAIL timeout_en en=%h required 00", sensor_enable);
    end
    snap = resp_count;
    repeat (30) @(negedge clock);
    checks++;
    if (resp_count != snap) begin
      errors++; $display("FAIL busy_ignore extra=%0d required 0", resp_count - snap);
    end
  endtask

  task automatic test_loop();
    logic got; logic [7:0] c, v, a; int cyc, snap;
    send_req(8'h04, 8'h02);
    wait_resp(40, got, c, v, a, cyc);
    checks++;
    if (!got || {c, v, a} !== 24'h0E_28_02) begin
      errors++; $display("FAIL loop_start got=%b resp=%h/%h/%h required 0E/28/02", got, c, v, a);
    end
    wait_resp(150, got, c, v, a, cyc);
    checks++;
    if (!got || cyc < 95 || cyc > 125 || {c, v, a} !== 24'h0E_28_02) begin
      errors++;
      $display("FAIL loop_first got=%b cyc=%0d resp=%h/%h/%h required 95..125 0E/28/02",
               got, cyc, c, v, a);
    end
    wait_resp(150, got, c, v, a, cyc);
    checks++;
    if (!got || cyc < 98 || cyc > 102 || {c, v, a} !== 24'h0E_28_02) begin
      errors++;
      $display("FAIL loop_period got=%b cyc=%0d resp=%h/%h/%h required 98..102 0E/28/02",
               got, cyc, c, v, a);
    end
    send_req(8'h01, 8'h02);
    wait_resp(10, got, c, v, a, cyc);
    checks++;
    if (!got || cyc != 2 || {c, v, a} !== 24'hFF_FF_02) begin
      errors++;
      $display("FAIL loop_block got=%b cyc=%0d resp=%h/%h/%h required 2 FF/FF/02", got, cyc,
               c, v, a);
    end
    send_req(8'h06, 8'h02);
    wait_resp(10, got, c, v, a, cyc);
    checks++;
    if (!got || {c, v, a} !== 24'h0B_0B_02) begin
      errors++; $display("FAIL loop_stop got=%b resp=%h/%h/%h required 0B/0B/02", got, c, v, a);
    end
    snap = resp_count;
    repeat (250) @(negedge clock);
    checks++;
    if (resp_count != snap) begin
      errors++; $display("FAIL loop_quiet extra=%0d required 0", resp_count - snap);
    end
  endtask

  task automatic test_tick_priority();
    logic got; logic [7:0] c, v, a; int cyc;
    logic [23:0] exp [7];
    exp = '{24'h0D_19_01, 24'h0E_28_02, 24'h0D_19_01, 24'h0E_28_02,
            24'h1F_1F_04, 24'h0D_19_01, 24'h0E_28_02};
    send_req(8'h03, 8'h01);
    wait_resp(40, got, c, v, a, cyc);
    send_req(8'h04, 8'h02);
    for (int k = 1; k < 7; k++) begin
      // Slow host read on silent channel 3 straddles the next tick of both looping channels.
      if (k == 4) begin
        repeat (40) @(negedge clock);
        send_req(8'h01, 8'h04);
      end
      wait_resp(150, got, c, v, a, cyc);
      checks++;
      if (!got || {c, v, a} !== exp[k]) begin
        errors++;
        $display("FAIL tick_order_%0d got=%b resp=%h/%h/%h required %h", k, got, c, v, a,
                 exp[k]);
      end
    end
    send_req(8'h05, 8'h01);
    wait_resp(10, got, c, v, a, cyc);
    checks++;
    if (!got || {c, v, a} !== 24'h0A_0A_01) begin
      errors++; $display("FAIL tick_stop0 got=%b resp=%h/%h/%h required 0A/0A/01", got, c, v, a);
    end
    send_req(8'h06, 8'h02);
    wait_resp(40, got, c, v, a, cyc);
    checks++;
    if (!got || {c, v, a} !== 24'h0B_0B_02) begin
      errors++; $display("FAIL tick_stop1 got=%b resp=%h/%h/%h required 0B/0B/02", got, c, v, a);
    end
  endtask

  task automatic test_reset_mid_read();
    logic got; logic [7:0] c, v, a; int cyc, snap;
    send_req(8'h03, 8'h01);
    wait_resp(40, got, c, v, a, cyc);
    send_req(8'h01, 8'h04);
    repeat (5) @(negedge clock);
    checks++;
    if (sensor_enable !== 8'h08) begin
      errors++; $display("FAIL mid_read_en en=%h required 08", sensor_enable);
    end
    reset_n = 1'b0;
    @(negedge clock);
    checks++;
    if (sensor_enable !== '0 || response_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort en=%h valid=%b busy=%b required 00/0/0", sensor_enable,
               response_valid, busy);
    end
    @(negedge clock);
    reset_n = 1'b1;
    snap = resp_count;
    repeat (200) @(negedge clock);
    checks++;
    if (resp_count != snap) begin
      errors++; $display("FAIL reset_quiet extra=%0d required 0", resp_count - snap);
    end
    send_req(8'h01, 8'h01);
    wait_resp(40, got, c, v, a, cyc);
    checks++;
    if (!got || {c, v, a} !== 24'h09_19_01) begin
      errors++;
      $display("FAIL reset_mode_clear got=%b resp=%h/%h/%h required 09/19/01", got, c, v, a);
    end
  endtask

  initial begin : main
    for (int i = 0; i < N; i++) fe_frame[i] = 40'h00_00_00_00_00;
    fe_frame[0] = 40'h32_00_19_00_4B;
    fe_frame[1] = 40'h28_05_1A_03_4A;
    fe_frame[2] = 40'h32_00_19_00_00;
    fe_frame[4] = 40'h10_20_30_40_A0;
    fe_frame[7] = 40'hFF_FF_01_01_00;
    fe_silent = 8'h08;
    fe_err    = 8'h10;
    test_reset();
    test_read_temp();
    test_reads();
    test_decode();
    test_timeout();
    test_loop();
    test_tick_priority();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sensor_hub_dispatcher.md
Name: sensor_hub_dispatcher

Overview:
- Parametrised, multi-channel successor to the single-DHT11 command handler.
- Decodes host request command and address, then drives one of NUM_SENSORS 40-bit sensor front-ends.
- Validates each frame (front-end error, checksum, timeout) and returns a command/value/address triple with a one-cycle valid strobe.
- Supports independent continuous sensing per channel, scheduled by a shared period counter. Sits between the UART command layer and the sensor front-ends.

Parameters:
- NUM_SENSORS, 8, number of sensor channels (1..32).
- ADDR_BASE, 8'h01, address of channel 0; channel i answers at ADDR_BASE+i.
- LOOP_PERIOD, 100000000, clock cycles between continuous-sensing ticks (2 s at 50 MHz).
- TIMEOUT_CYCLES, 50000000, maximum wait for sensor_done or sensor_error.
- CNT_W, 27, width of the period and timeout counters; must hold both values.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous reset, active-low
- enable  in  1  request strobe; request_command/request_address sampled when high and busy=0
- request_command  in  8  command code
- request_address  in  8  target sensor address
- sensor_enable  out  NUM_SENSORS  per-channel read start/hold
- sensor_data  in  40*NUM_SENSORS  channel i at [40*i+39:40*i]: hum_int, hum_dec, temp_int, temp_dec, checksum (MSB first)
- sensor_error  in  NUM_SENSORS  front-end error flag
- sensor_done  in  NUM_SENSORS  frame-complete flag
- busy  out  1  high from request acceptance until the cycle after response_valid
- response_valid  out  1  one-cycle pulse; response outputs valid and held until next pulse
- response_command  out  8  response code
- response_value  out  8  response data
- response_address  out  8  address the response refers to

Behaviour:
- One clock; reset is synchronous and active-low (reset_n sampled on rising clock).
- Reset values: all outputs 0, all loop modes OFF, pending bits 0, counters 0, FSM in IDLE. Reset mid-read drops sensor_enable the next edge.
- FSM states: IDLE, DECODE, START, WAIT, CHECK, RESP.
- IDLE: a host request (enable=1) beats a pending loop read in the same cycle. Otherwise serve the lowest-index pending channel.
- DECODE, in priority order:
  - Address outside ADDR_BASE..ADDR_BASE+NUM_SENSORS-1 -> EE/EE.
  - Channel in loop mode and command not 03..06 -> FF/FF.
  - 05 or 06 -> clear loop mode, respond 0A/0A or 0B/0B (even if already off).
  - Unknown command -> 45/45.
  - Read commands (AC, 01, 02, 03, 04) -> START.
- START: assert sensor_enable[i], clear timeout counter, go to WAIT.
- WAIT: hold sensor_enable[i] until sensor_done[i] or sensor_error[i], or until the counter reaches TIMEOUT_CYCLES; then deassert and go to CHECK.
- CHECK: ok = no error, no timeout, and checksum = (sum of bytes 4..1) mod 256.
  - Not ok -> 1F/1F for every read command.
  - Ok: AC -> 07/07; 01 -> 09/temp_int; 02 -> 08/hum_int.
  - Ok: 03 -> 0D/temp_int and set mode TEMP; 04 -> 0E/hum_int and set mode HUM.
  - Errors on 03/04 leave mode unchanged.
- RESP: pulse response_valid, return to IDLE.
- Latency: non-read responses pulse 2 cycles after enable is sampled. Read responses pulse 2 cycles after the cycle sensor_done/error or timeout is sampled.
- Loop scheduler:
  - Period counter free-runs 0..LOOP_PERIOD-1 while any channel is in loop mode; it is held at 0 otherwise.
  - At wrap, set pending[i] for every looping channel. Bits already set stay set, so there is no double read.
  - A loop read responds 0D or 0E with the channel's address. Pending[i] clears on service or when the channel leaves loop mode.
- enable while busy=1: ignored, no response.
- Width rule: checksum compare in 8 bits, carries discarded.

Optional Feature:
- Macro SENSOR_FRAC_EN.
- Defined: command 07 -> 19/temp_dec and command 08 -> 18/hum_dec, both via full read path and checksum; both are also accepted as non-loop commands.
- Undefined: 07 and 08 fall into the unknown-command path (45/45).

Test Plan:
- Reset, addr 01, cmd 01, front-end returns 32,00,19,00,4B plus done -> 09/19, address 01, sensor_enable[0] low after done.
- Addr 03, cmd 02, frame with checksum 00 (sum 4B) -> 1F/1F; addr 20 with NUM_SENSORS=8 -> EE/EE two cycles after enable.
- Addr 02, cmd 04, LOOP_PERIOD=100 -> 0E/hum, then 0E every ~100 cycles. Cmd 01 to addr 02 -> FF/FF. Cmd 06 -> 0B/0B, no further loop responses.
- Channels 0 and 1 both looping, host request arrives on the tick cycle -> host response first, then channel 0, then channel 1.
- No done/error, TIMEOUT_CYCLES=50 -> 1F/1F about 52 cycles after request, sensor_enable low. enable pulsed while busy -> no extra response.
- reset_n low during WAIT -> sensor_enable 0 next edge, loop modes cleared, no response_valid.
